id_hazard_scoreboard: RTL and testbench
=======================================

ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

Interface
REQ-001 Parameter NUM_RD, default 2: number of decode source-register read ports.
REQ-002 Parameter REG_ADDR_W, default 5: register address width; NUM_REGS = 2**REG_ADDR_W.
REQ-003 Parameter LAT_W, default 4: width of long-latency countdown per register.
REQ-004 Parameter FWD_EN, default 1: 1 = forwarding enabled, 0 = stall on every RAW match.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  reset is asynchronous and active-high.
REQ-007 rs_addr_i  in  NUM_RD*REG_ADDR_W  source addresses; port j at bits [j*REG_ADDR_W +: REG_ADDR_W].
REQ-008 rs_used_i  in  NUM_RD  port j source actually read by the decoding instruction.
REQ-009 issue_valid_i  in  1  instruction present in ID.
REQ-010 issue_rd_addr_i / issue_rd_wr_i  in  REG_ADDR_W / 1  ID destination and write enable.
REQ-011 issue_long_i / issue_lat_i  in  1 / LAT_W  ID op is long-latency (mul/div) and its latency in cycles.
REQ-012 ex_rd_addr_i / ex_rd_wr_i / ex_is_load_i  in  REG_ADDR_W / 1 / 1  EX-stage destination info.
REQ-013 mem_rd_addr_i / mem_rd_wr_i, wb_rd_addr_i / wb_rd_wr_i  in  REG_ADDR_W / 1  MEM and WB destination info.
REQ-014 flush_i  in  1  ID instruction is being squashed this cycle.
REQ-015 stall_o  out  1  hold IF/ID, insert bubble into EX.
REQ-016 fwd_sel_o  out  NUM_RD*2  per port: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-017 busy_o  out  NUM_REGS  scoreboard busy bit per register.
REQ-018 stall_cnt_o  out  16  saturating count of stalled cycles.

Function
REQ-019 A port j is active only when rs_used_i[j]=1 and its address is nonzero; inactive ports never cause stall and drive fwd_sel 00.
REQ-020 A stage matches port j when its wr flag=1, its rd address is nonzero and equals the port address.
REQ-021 Scoreboard hazard: active port whose address has busy_o bit set SHALL raise stall.
REQ-022 WAW hazard: issue_rd_wr_i=1, issue_rd_addr_i nonzero and busy for that address SHALL raise stall.
REQ-023 FWD_EN=1: EX match with ex_is_load_i=1 SHALL raise stall (load-use); otherwise fwd_sel = first match in priority EX > MEM > WB, else 00.
REQ-024 FWD_EN=0: any EX/MEM/WB match SHALL raise stall; fwd_sel_o constantly 00.
REQ-025 stall_o = issue_valid_i AND NOT flush_i AND (any hazard of REQ-021..024); purely combinational, zero-cycle latency.
REQ-026 Issue accepted = issue_valid_i AND NOT stall_o AND NOT flush_i.
REQ-027 Accepted issue with issue_long_i=1, issue_rd_wr_i=1, nonzero rd: counter[rd] loads max(issue_lat_i,1), busy[rd] set at that edge.
REQ-028 Each edge every nonzero counter not being loaded decrements; busy clears on the edge counter goes 1->0; latency N keeps busy for N cycles after the issue cycle.
REQ-029 Load and decrement never target the same register in one cycle (REQ-022 blocks it); x0 never becomes busy.
REQ-030 flush_i does not cancel in-flight long ops; it only blocks recording a new one.
REQ-031 stall_cnt_o increments on each edge with stall_o=1; holds at 16'hFFFF.

Reset
REQ-032 reset=1 SHALL immediately clear all counters, busy_o to 0 and stall_cnt_o to 0, including mid-countdown; stall_o and fwd_sel_o then follow REQ-019..025 with an empty scoreboard.
REQ-033 First edge after reset deassertion SHALL behave as a normal operating edge.

Verification
REQ-034 EX writes x5 (ALU), ID rs1=x5 used -> stall_o=0, fwd_sel port0=01.
REQ-035 EX load x7, ID rs2=x7 used -> stall_o=1; next cycle load in MEM -> stall_o=0, fwd_sel port1=10.
REQ-036 Long issue x9 lat 3 in cycle 0, ID reads x9 -> stall_o=1 cycles 1-3, busy_o[9]=0 and stall_o=0 in cycle 4.
REQ-037 ID rs1=x0, EX/MEM/WB all writing x0 -> stall_o=0, fwd_sel 00; FWD_EN=0 with EX writing x5, rs1=x5 -> stall_o=1.
REQ-038 reset pulsed while busy_o[9]=1, counter=2 -> busy_o=0, stall_cnt_o=0 without waiting for a clock edge.
REQ-039 stall_o held 1 for 65540 cycles -> stall_cnt_o=16'hFFFF and stays there.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard
//
// Decode-stage hazard unit for an in-order pipeline. It combines two sources
// of read-after-write / write-after-write hazards:
//   * bypass-network checks against the EX, MEM and WB destination registers
//     (forwarding selects or load-use stalls), and
//   * a per-register scoreboard for long-latency ops (mul/div). Each register
//     has a countdown that keeps it busy for the op's latency after issue.
//
// Ports
//   clk, reset                 single clock, asynchronous active-high reset
//   rs_addr_i / rs_used_i      decode source addresses (port j at
//                              [j*REG_ADDR_W +: REG_ADDR_W]) and read flags
//   issue_valid_i              instruction present in ID
//   issue_rd_addr_i/_rd_wr_i   ID destination and its write enable
//   issue_long_i/_lat_i        ID op is long-latency and its latency
//   ex_* / mem_* / wb_*        downstream destination info (EX also: is load)
//   flush_i                    ID instruction squashed this cycle
//   stall_o                    hold IF/ID, bubble into EX (combinational)
//   fwd_sel_o                  per port: 00 regfile, 01 EX, 10 MEM, 11 WB
//   busy_o                     scoreboard busy bit per register
//   stall_cnt_o                saturating count of stalled cycles
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module id_hazard_scoreboard #(
  parameter int NUM_RD     = 2,
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 4,
  parameter int FWD_EN     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rs_addr_i,
  input  logic [NUM_RD-1:0]            rs_used_i,
  input  logic                         issue_valid_i,
  input  logic [REG_ADDR_W-1:0]        issue_rd_addr_i,
  input  logic                         issue_rd_wr_i,
  input  logic                         issue_long_i,
  input  logic [LAT_W-1:0]             issue_lat_i,
  input  logic [REG_ADDR_W-1:0]        ex_rd_addr_i,
  input  logic                         ex_rd_wr_i,
  input  logic                         ex_is_load_i,
  input  logic [REG_ADDR_W-1:0]        mem_rd_addr_i,
  input  logic                         mem_rd_wr_i,
  input  logic [REG_ADDR_W-1:0]        wb_rd_addr_i,
  input  logic                         wb_rd_wr_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic [NUM_RD*2-1:0]          fwd_sel_o,
  output logic [(2**REG_ADDR_W)-1:0]   busy_o,
  output logic [15:0]                  stall_cnt_o
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  // A stage can feed a source only if it really writes a non-x0 register
  // that equals the source address.
  function automatic logic stage_match(input logic                  wr,
                                       input logic [REG_ADDR_W-1:0] st_addr,
                                       input logic [REG_ADDR_W-1:0] src_addr);
    return wr && (st_addr != {REG_ADDR_W{1'b0}}) && (st_addr == src_addr);
  endfunction

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_r;
  logic [NUM_REGS-1:0]            busy_r;
  logic [15:0]                    stall_cnt_r;

  logic [REG_ADDR_W-1:0] port_addr_s [NUM_RD];
  logic [NUM_RD-1:0]     port_act_s;
  logic [NUM_RD-1:0]     ex_m_s;
  logic [NUM_RD-1:0]     mem_m_s;
  logic [NUM_RD-1:0]     wb_m_s;
  logic [NUM_RD-1:0]     sb_haz_s;
  logic [NUM_RD-1:0]     raw_haz_s;
  logic [NUM_RD*2-1:0]   fwd_s;
  logic                  waw_haz_s;
  logic                  stall_s;
  logic                  accept_s;
  logic                  load_en_s;
  logic [LAT_W-1:0]      load_val_s;

  // Per-port decode: activity, stage matches and per-port hazard terms.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      port_addr_s[j] = rs_addr_i[j*REG_ADDR_W +: REG_ADDR_W];
      port_act_s[j]  = rs_used_i[j] && (port_addr_s[j] != {REG_ADDR_W{1'b0}});
      ex_m_s[j]      = stage_match(ex_rd_wr_i,  ex_rd_addr_i,  port_addr_s[j]);
      mem_m_s[j]     = stage_match(mem_rd_wr_i, mem_rd_addr_i, port_addr_s[j]);
      wb_m_s[j]      = stage_match(wb_rd_wr_i,  wb_rd_addr_i,  port_addr_s[j]);
      sb_haz_s[j]    = port_act_s[j] && busy_r[port_addr_s[j]];
      // With forwarding only a load in EX is too late to bypass; without it
      // every in-flight producer must drain through the register file.
      raw_haz_s[j]   = (FWD_EN != 0)
                     ? (port_act_s[j] && ex_m_s[j] && ex_is_load_i)
                     : (port_act_s[j] && (ex_m_s[j] || mem_m_s[j] || wb_m_s[j]));
    end
  end

  // Forwarding mux selects, youngest producer wins.
  always_comb begin
    fwd_s = {(NUM_RD*2){1'b0}};
    for (int j = 0; j < NUM_RD; j++) begin
      if ((FWD_EN == 0) || !port_act_s[j]) begin
        fwd_s[j*2 +: 2] = 2'b00;
      end else if (ex_m_s[j]) begin
        fwd_s[j*2 +: 2] = 2'b01;
      end else if (mem_m_s[j]) begin
        fwd_s[j*2 +: 2] = 2'b10;
      end else if (wb_m_s[j]) begin
        fwd_s[j*2 +: 2] = 2'b11;
      end else begin
        fwd_s[j*2 +: 2] = 2'b00;
      end
    end
  end

  // Stall decision, issue acceptance and scoreboard load value.
  always_comb begin
    waw_haz_s  = issue_rd_wr_i && (issue_rd_addr_i != {REG_ADDR_W{1'b0}})
               && busy_r[issue_rd_addr_i];
    stall_s    = issue_valid_i && !flush_i && ((|sb_haz_s) || (|raw_haz_s) || waw_haz_s);
    accept_s   = issue_valid_i && !stall_s && !flush_i;
    // The WAW check guarantees the target counter is idle when it is loaded.
    load_en_s  = accept_s && issue_long_i && issue_rd_wr_i
               && (issue_rd_addr_i != {REG_ADDR_W{1'b0}});
    load_val_s = (issue_lat_i == {LAT_W{1'b0}}) ? LAT_W'(1) : issue_lat_i;
  end

  // Per-register latency countdown; busy drops on the edge the count leaves 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {(NUM_REGS*LAT_W){1'b0}};
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (load_en_s && (issue_rd_addr_i == REG_ADDR_W'(r))) begin
          cnt_r[r]  <= load_val_s;
          busy_r[r] <= 1'b1;
        end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
          cnt_r[r]  <= cnt_r[r] - LAT_W'(1);
          busy_r[r] <= (cnt_r[r] != LAT_W'(1));
        end else begin
          cnt_r[r]  <= cnt_r[r];
          busy_r[r] <= 1'b0;
        end
      end
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_o     = stall_s;
  assign fwd_sel_o   = fwd_s;
  assign busy_o      = busy_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_id_hazard_scoreboard;
  localparam int NR = 2, AW = 5, LW = 4, NREG = 32;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0]    rs_a [NR];
  logic [NR*AW-1:0] rs_addr;
  logic [NR-1:0]    rs_used;
  logic issue_valid, issue_wr, issue_long, ex_wr, ex_load, mem_wr, wb_wr, flush;
  logic [AW-1:0] issue_rd, ex_rd, mem_rd, wb_rd;
  logic [LW-1:0] issue_lat;
  logic stall1, stall0;
  logic [NR*2-1:0] fwd1, fwd0;
  logic [NREG-1:0] busy1, busy0;
  logic [15:0] cnt1, cnt0;

  assign rs_addr = {rs_a[1], rs_a[0]};

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.NUM_RD(NR), .REG_ADDR_W(AW), .LAT_W(LW), .FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .rs_addr_i(rs_addr), .rs_used_i(rs_used),
    .issue_valid_i(issue_valid), .issue_rd_addr_i(issue_rd), .issue_rd_wr_i(issue_wr),
    .issue_long_i(issue_long), .issue_lat_i(issue_lat),
    .ex_rd_addr_i(ex_rd), .ex_rd_wr_i(ex_wr), .ex_is_load_i(ex_load),
    .mem_rd_addr_i(mem_rd), .mem_rd_wr_i(mem_wr), .wb_rd_addr_i(wb_rd), .wb_rd_wr_i(wb_wr),
    .flush_i(flush), .stall_o(stall1), .fwd_sel_o(fwd1), .busy_o(busy1), .stall_cnt_o(cnt1));

  id_hazard_scoreboard #(.NUM_RD(NR), .REG_ADDR_W(AW), .LAT_W(LW), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .reset(reset), .rs_addr_i(rs_addr), .rs_used_i(rs_used),
    .issue_valid_i(issue_valid), .issue_rd_addr_i(issue_rd), .issue_rd_wr_i(issue_wr),
    .issue_long_i(issue_long), .issue_lat_i(issue_lat),
    .ex_rd_addr_i(ex_rd), .ex_rd_wr_i(ex_wr), .ex_is_load_i(ex_load),
    .mem_rd_addr_i(mem_rd), .mem_rd_wr_i(mem_wr), .wb_rd_addr_i(wb_rd), .wb_rd_wr_i(wb_wr),
    .flush_i(flush), .stall_o(stall0), .fwd_sel_o(fwd0), .busy_o(busy0), .stall_cnt_o(cnt0));

  int ncmp = 0;
  int nfail = 0;
  // Reference model: a register is busy during cycles (issue, busy_until].
  int tcyc;
  int bu1 [NREG];
  int bu0 [NREG];
  int sc1, sc0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input bit fe, input int r);
    if (r == 0) return 1'b0;
    return fe ? (tcyc <= bu1[r]) : (tcyc <= bu0[r]);
  endfunction

  function automatic logic [NREG-1:0] m_bvec(input bit fe);
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy(fe, r);
    return v;
  endfunction

  function automatic bit m_stall(input bit fe);
    bit haz;
    int a;
    bit exm, mm, wm;
    if (!issue_valid || flush) return 1'b0;
    haz = 1'b0;
    for (int j = 0; j < NR; j++) begin
      a = int'(rs_a[j]);
      if (rs_used[j] && a != 0) begin
        exm = ex_wr && (int'(ex_rd) == a);
        mm  = mem_wr && (int'(mem_rd) == a);
        wm  = wb_wr && (int'(wb_rd) == a);
        if (m_busy(fe, a)) haz = 1'b1;
        if (fe && exm && ex_load) haz = 1'b1;
        if (!fe && (exm || mm || wm)) haz = 1'b1;
      end
    end
    if (issue_wr && issue_rd != 0 && m_busy(fe, int'(issue_rd))) haz = 1'b1;
    return haz;
  endfunction

  function automatic logic [NR*2-1:0] m_fwd(input bit fe);
    logic [NR*2-1:0] v;
    logic [1:0] s;
    v = '0;
    for (int j = 0; j < NR; j++) begin
      s = 2'd0;
      if (fe && rs_used[j] && rs_a[j] != 0) begin
        if (ex_wr && ex_rd == rs_a[j]) s = 2'd1;
        else if (mem_wr && mem_rd == rs_a[j]) s = 2'd2;
        else if (wb_wr && wb_rd == rs_a[j]) s = 2'd3;
      end
      v[j*2 +: 2] = s;
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NREG; r++) begin bu1[r] = -1; bu0[r] = -1; end
    sc1 = 0; sc0 = 0;
  endtask

  task automatic m_edge();
    bit s1, s0, rec;
    int n;
    s1 = m_stall(1'b1);
    s0 = m_stall(1'b0);
    n = (issue_lat == 0) ? 1 : int'(issue_lat);
    rec = issue_valid && !flush && issue_long && issue_wr && issue_rd != 0;
    if (rec && !s1) bu1[issue_rd] = tcyc + n;
    if (rec && !s0) bu0[issue_rd] = tcyc + n;
    if (s1 && sc1 < 65535) sc1++;
    if (s0 && sc0 < 65535) sc0++;
    tcyc++;
  endtask

  task automatic idle();
    rs_a[0] = '0; rs_a[1] = '0; rs_used = '0; issue_valid = 1'b0;
    issue_rd = '0; issue_wr = 1'b0; issue_long = 1'b0; issue_lat = '0;
    ex_rd = '0; ex_wr = 1'b0; ex_load = 1'b0; mem_rd = '0; mem_wr = 1'b0;
    wb_rd = '0; wb_wr = 1'b0; flush = 1'b0;
  endtask

  task automatic check_all();
    chk("stall_fwd", stall1, m_stall(1'b1));
    chk("fwdsel_fwd", fwd1, m_fwd(1'b1));
    chk("busy_fwd", busy1, m_bvec(1'b1));
    chk("cnt_fwd", cnt1, sc1);
    chk("stall_nofwd", stall0, m_stall(1'b0));
    chk("fwdsel_nofwd", fwd0, m_fwd(1'b0));
    chk("busy_nofwd", busy0, m_bvec(1'b0));
    chk("cnt_nofwd", cnt0, sc0);
  endtask

  // Inputs are applied 1 time unit after a rising edge; settle samples mid-cycle.
  task automatic settle();
    #3;
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic long_issue(input logic [AW-1:0] rd, input logic [LW-1:0] lat);
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_long = 1'b1; issue_rd = rd; issue_lat = lat;
  endtask

  initial begin
    tcyc = 0;
    m_reset();
    idle();
    reset = 1'b1;
    #1;
    chk("rst_busy", busy1, '0);
    chk("rst_cnt", cnt1, '0);
    chk("rst_stall", stall1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU result in EX forwarded; non-forwarding variant must stall
    idle(); issue_valid = 1'b1; rs_a[0] = 5'd5; rs_used = 2'b01; ex_rd = 5'd5; ex_wr = 1'b1;
    settle();
    chk("alu_fwd_stall", stall1, 1'b0);
    chk("alu_fwd_sel", fwd1[1:0], 2'b01);
    chk("nofwd_ex_stall", stall0, 1'b1);
    adv();

    // x0 is never a hazard source
    idle(); issue_valid = 1'b1; rs_used = 2'b11;
    ex_wr = 1'b1; mem_wr = 1'b1; wb_wr = 1'b1;
    settle();
    chk("x0_stall", stall1, 1'b0);
    chk("x0_fwd", fwd1, 4'b0000);
    chk("x0_stall_nofwd", stall0, 1'b0);
    adv();

    // load-use on port 1, then forwarded from MEM
    idle(); issue_valid = 1'b1; rs_a[1] = 5'd7; rs_used = 2'b10;
    ex_rd = 5'd7; ex_wr = 1'b1; ex_load = 1'b1;
    settle();
    chk("loaduse_stall", stall1, 1'b1);
    adv();
    ex_wr = 1'b0; ex_load = 1'b0; mem_rd = 5'd7; mem_wr = 1'b1;
    settle();
    chk("loaduse_mem_stall", stall1, 1'b0);
    chk("loaduse_mem_sel", fwd1[3:2], 2'b10);
    adv();

    // long op x9 latency 3: busy and stalling for three cycles
    long_issue(5'd9, 4'd3);
    settle();
    adv();
    idle(); issue_valid = 1'b1; rs_a[0] = 5'd9; rs_used = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk("long_stall", stall1, 1'b1);
      chk("long_busy9", busy1[9], 1'b1);
      adv();
    end
    settle();
    chk("long_done_stall", stall1, 1'b0);
    chk("long_done_busy9", busy1[9], 1'b0);
    adv();

    // latency 0 behaves as latency 1
    long_issue(5'd4, 4'd0);
    settle(); adv();
    idle(); settle();
    chk("lat0_busy", busy1[4], 1'b1);
    adv(); settle();
    chk("lat0_clear", busy1[4], 1'b0);
    adv();

    // WAW against a busy destination
    long_issue(5'd9, 4'd2);
    settle(); adv();
    idle(); issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd9;
    settle();
    chk("waw_stall", stall1, 1'b1);
    adv(); adv();

    // flush masks stalls and blocks recording a long op
    long_issue(5'd3, 4'd5); flush = 1'b1; rs_a[0] = 5'd9; rs_used = 2'b01;
    ex_rd = 5'd9; ex_wr = 1'b1; ex_load = 1'b1;
    settle();
    chk("flush_stall", stall1, 1'b0);
    adv();
    idle(); settle();
    chk("flush_busy3", busy1[3], 1'b0);
    adv();

    // async reset mid-countdown
    long_issue(5'd9, 4'd3);
    settle(); adv();
    idle(); settle(); adv();
    idle(); issue_valid = 1'b1; rs_a[0] = 5'd9; rs_used = 2'b01;
    #2;
    chk("pre_rst_busy9", busy1[9], 1'b1);
    chk("pre_rst_stall", stall1, 1'b1);
    reset = 1'b1;
    #1;
    m_reset();
    chk("async_rst_busy", busy1, '0);
    chk("async_rst_cnt", cnt1, '0);
    chk("async_rst_busy_nofwd", busy0, '0);
    chk("async_rst_stall", stall1, 1'b0);
    reset = 1'b0;
    #1;
    check_all();
    adv();
    // first edge after reset is a normal edge
    long_issue(5'd9, 4'd2);
    settle(); adv();
    idle(); settle();
    chk("post_rst_busy9", busy1[9], 1'b1);
    adv(); adv(); adv();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      issue_valid = ($urandom_range(0, 9) < 8);
      rs_a[0] = AW'($urandom_range(0, 7)); rs_a[1] = AW'($urandom_range(0, 7));
      rs_used = NR'($urandom_range(0, 3));
      issue_rd = AW'($urandom_range(0, 7)); issue_wr = 1'($urandom_range(0, 1));
      issue_long = ($urandom_range(0, 9) < 3); issue_lat = LW'($urandom_range(0, 5));
      ex_rd = AW'($urandom_range(0, 7)); ex_wr = 1'($urandom_range(0, 1));
      ex_load = 1'($urandom_range(0, 1));
      mem_rd = AW'($urandom_range(0, 7)); mem_wr = 1'($urandom_range(0, 1));
      wb_rd = AW'($urandom_range(0, 7)); wb_wr = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      settle();
      adv();
    end

    // saturation of the stall counter
    idle(); issue_valid = 1'b1; rs_a[0] = 5'd5; rs_used = 2'b01;
    ex_rd = 5'd5; ex_wr = 1'b1; ex_load = 1'b1;
    settle();
    for (int i = 0; i < 65540; i++) adv();
    #3;
    chk("sat_cnt", cnt1, 16'hFFFF);
    chk("sat_cnt_nofwd", cnt0, 16'hFFFF);
    check_all();
    adv(); adv(); adv();
    #3;
    chk("sat_hold", cnt1, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
